// File: rtl/fetch_unit_ras_pkg.sv
// ISA constants and width helpers shared by the fetch unit and its users.
// No logic; constants and constant functions only.
package fetch_unit_ras_pkg;

    localparam int OP_SIZE_DEF   = 4;
    localparam int ARG_SIZE_DEF  = 3;
    localparam int ARG_NUM_DEF   = 2;
    localparam int PC_W_DEF      = 6;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic [3:0] {
        OP_LOAD = 4'b0000,
        OP_MOVE = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_BRN  = 4'b0100,
        OP_LDPC = 4'b0101,
        OP_BXLR = 4'b0110,
        OP_CALL = 4'b0111,
        OP_RET  = 4'b1000
    } opcode_e;

    typedef enum logic [2:0] {
        REG_NA = 3'b000,
        REG_R1 = 3'b001,
        REG_R2 = 3'b010,
        REG_R3 = 3'b011,
        REG_R4 = 3'b100,
        REG_R5 = 3'b101,
        REG_R6 = 3'b110,
        REG_PC = 3'b111
    } reg_e;

    function automatic int iw_of(input int op_size, input int arg_size, input int arg_num);
        return op_size + arg_num * arg_size;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_unit_ras_if.sv
// Controller/decoder/programmer side bundle of the fetch unit.
// Pure wiring; slave modport is the fetch unit, master is the driver.
interface fetch_unit_ras_if #(
    parameter int PC_W = 6,
    parameter int IW   = 10,
    parameter int CW   = 3
);
    logic            done;
    logic            branch;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] target;
    logic            prog_we;
    logic [PC_W-1:0] prog_addr;
    logic [IW-1:0]   prog_data;
    logic            export_pc;
    logic            err_clr;
    logic [IW-1:0]   instruction;
    logic [CW-1:0]   ras_count;
    logic            ras_full;
    logic            ras_empty;
    logic            err_ovf;
    logic            err_unf;

    modport slave (
        input  done, branch, call, ret, target,
        input  prog_we, prog_addr, prog_data, export_pc, err_clr,
        output instruction, ras_count, ras_full, ras_empty, err_ovf, err_unf
    );

    modport master (
        output done, branch, call, ret, target,
        output prog_we, prog_addr, prog_data, export_pc, err_clr,
        input  instruction, ras_count, ras_full, ras_empty, err_ovf, err_unf
    );
endinterface

// File: rtl/fetch_unit_ras_ras_stack.sv
// LIFO of return addresses; push/pop take effect on the next edge, top/count are combinational.
// Push while full and pop while empty are ignored; the caller owns error reporting.
module ras_stack #(
    parameter  int PC_W      = 6,
    parameter  int RAS_DEPTH = 4,
    localparam int CW        = $clog2(RAS_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);
    localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0] mem [RAS_DEPTH];
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   top_idx;

    assign top_idx = cnt - CW'(1);
    assign full    = (cnt == CW'(RAS_DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign top     = empty ? '0 : mem[top_idx[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Entry storage needs no reset: only slots below cnt are ever read.
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[cnt[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit_ras.sv
// Fetch unit: writable store, PC, return-address stack; PC/RAS update next edge, instruction read is zero-latency.
// No backpressure: every request resolves in one cycle by fixed priority; stack misuse sets sticky flags.
module fetch_unit_ras
    import fetch_unit_ras_pkg::*;
#(
    parameter  int OP_SIZE   = OP_SIZE_DEF,
    parameter  int ARG_SIZE  = ARG_SIZE_DEF,
    parameter  int ARG_NUM   = ARG_NUM_DEF,
    parameter  int PC_W      = PC_W_DEF,
    parameter  int RAS_DEPTH = RAS_DEPTH_DEF,
    localparam int IW        = iw_of(OP_SIZE, ARG_SIZE, ARG_NUM),
    localparam int CW        = cnt_w(RAS_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    fetch_unit_ras_if.slave bus,
    output wire [PC_W-1:0]  out_pc
);
    logic [IW-1:0]   store [2**PC_W];
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] nxt_pc;
    logic            push;
    logic            pop;
    logic            set_ovf;
    logic            set_unf;
    logic            ovf_q;
    logic            unf_q;
    logic [PC_W-1:0] ras_top;
    logic [CW-1:0]   ras_cnt;
    logic            ras_full;
    logic            ras_empty;

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc + PC_W'(1)),
        .top       (ras_top),
        .count     (ras_cnt),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // Priority branch > call > ret > done; a shadowed request has no effect at all.
    always_comb begin
        nxt_pc  = pc;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (bus.branch) begin
            nxt_pc = bus.target;
        end else if (bus.call) begin
            if (ras_full) begin
                set_ovf = 1'b1;
            end else begin
                push   = 1'b1;
                nxt_pc = bus.target;
            end
        end else if (bus.ret) begin
            if (ras_empty) begin
                set_unf = 1'b1;
            end else begin
                pop    = 1'b1;
                nxt_pc = ras_top;
            end
        end else if (bus.done) begin
            nxt_pc = pc + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc    <= nxt_pc;
            ovf_q <= set_ovf | (ovf_q & ~bus.err_clr);
            unf_q <= set_unf | (unf_q & ~bus.err_clr);
        end
    end

    // Programming port is deliberately independent of reset and control.
    always_ff @(posedge clk) begin
        if (bus.prog_we) begin
            store[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign bus.instruction = store[pc];
    assign bus.ras_count   = ras_cnt;
    assign bus.ras_full    = ras_full;
    assign bus.ras_empty   = ras_empty;
    assign bus.err_ovf     = ovf_q;
    assign bus.err_unf     = unf_q;
    assign out_pc          = bus.export_pc ? pc : 'z;

endmodule

// File: tb/tb_fetch_unit_ras.sv
// Directed plus randomized bench for fetch_unit_ras against a queue-based reference model.
module tb_fetch_unit_ras;
    localparam int PC_W  = 6;
    localparam int IW    = 10;
    localparam int DEPTH = 4;
    localparam int NPC   = 64;

    logic clk = 1'b0;
    logic rst;
    tri [PC_W-1:0] out_pc;

    fetch_unit_ras_if #(.PC_W(PC_W), .IW(IW), .CW(3)) bus ();

    fetch_unit_ras #(
        .OP_SIZE   (4),
        .ARG_SIZE  (3),
        .ARG_NUM   (2),
        .PC_W      (PC_W),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .out_pc (out_pc)
    );

    // Undriven out_pc floats to all ones, which makes high-Z observable.
    for (genvar g = 0; g < PC_W; g++) begin : g_pu
        pullup (out_pc[g]);
    end

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int            m_pc;
    int            m_stk[$];
    bit            m_ovf;
    bit            m_unf;
    logic [IW-1:0] m_store [NPC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst           = 1'b0;
        bus.done      = 1'b0;
        bus.branch    = 1'b0;
        bus.call      = 1'b0;
        bus.ret       = 1'b0;
        bus.target    = '0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.export_pc = 1'b1;
        bus.err_clr   = 1'b0;
    endtask

    task automatic model_step();
        bit ev_o;
        bit ev_u;
        ev_o = 1'b0;
        ev_u = 1'b0;
        if (bus.prog_we) m_store[bus.prog_addr] = bus.prog_data;
        if (rst) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (bus.branch) begin
                m_pc = int'(bus.target);
            end else if (bus.call) begin
                if (m_stk.size() < DEPTH) begin
                    m_stk.push_back((m_pc + 1) % NPC);
                    m_pc = int'(bus.target);
                end else begin
                    ev_o = 1'b1;
                end
            end else if (bus.ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else ev_u = 1'b1;
            end else if (bus.done) begin
                m_pc = (m_pc + 1) % NPC;
            end
            m_ovf = ev_o | (m_ovf & !bus.err_clr);
            m_unf = ev_u | (m_unf & !bus.err_clr);
        end
    endtask

    task automatic check_all();
        if (bus.export_pc) chk("out_pc", 32'(out_pc), m_pc);
        else chk("out_pc_z", 32'(out_pc), 32'h3F);
        chk("instruction", 32'(bus.instruction), 32'(m_store[m_pc]));
        chk("ras_count", 32'(bus.ras_count), m_stk.size());
        chk("ras_full", 32'(bus.ras_full), 32'(m_stk.size() == DEPTH));
        chk("ras_empty", 32'(bus.ras_empty), 32'(m_stk.size() == 0));
        chk("err_ovf", 32'(bus.err_ovf), 32'(m_ovf));
        chk("err_unf", 32'(bus.err_unf), 32'(m_unf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic go_branch(input int t);
        idle();
        bus.branch = 1'b1;
        bus.target = PC_W'(t);
        tick();
    endtask

    task automatic go_call(input int t);
        idle();
        bus.call   = 1'b1;
        bus.target = PC_W'(t);
        tick();
    endtask

    task automatic go_ret(input bit clr);
        idle();
        bus.ret     = 1'b1;
        bus.err_clr = clr;
        tick();
    endtask

    initial begin
        idle();
        m_pc  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);

        // Reset held while the whole store is programmed.
        rst = 1'b1;
        for (int i = 0; i < NPC; i++) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = PC_W'(i);
            bus.prog_data = IW'($urandom);
            tick();
        end
        idle();
        chk("reset_pc", 32'(out_pc), 0);
        chk("reset_count", 32'(bus.ras_count), 0);

        // Sequential advance and wrap.
        for (int i = 0; i < 4; i++) begin
            idle();
            bus.done = 1'b1;
            tick();
        end
        chk("seq_pc4", 32'(out_pc), 4);
        go_branch(63);
        idle();
        bus.done = 1'b1;
        tick();
        chk("seq_wrap", 32'(out_pc), 0);

        // Branch beats every other request.
        go_branch(5);
        idle();
        bus.branch = 1'b1;
        bus.call   = 1'b1;
        bus.ret    = 1'b1;
        bus.done   = 1'b1;
        bus.target = PC_W'(20);
        tick();
        chk("prio_pc", 32'(out_pc), 20);
        chk("prio_count", 32'(bus.ras_count), 0);

        // Nested call/return.
        go_branch(2);
        go_call(10);
        go_call(30);
        chk("nest_pc30", 32'(out_pc), 30);
        go_ret(1'b0);
        chk("nest_pc11", 32'(out_pc), 11);
        go_ret(1'b0);
        chk("nest_pc3", 32'(out_pc), 3);

        // Overflow, clear, unwind.
        go_branch(1);
        go_call(8);
        go_call(16);
        go_call(24);
        go_call(40);
        chk("ovf_full", 32'(bus.ras_full), 1);
        go_call(50);
        chk("ovf_pc", 32'(out_pc), 40);
        chk("ovf_flag", 32'(bus.err_ovf), 1);
        idle();
        bus.err_clr = 1'b1;
        tick();
        chk("ovf_clr", 32'(bus.err_ovf), 0);
        for (int i = 0; i < 4; i++) go_ret(1'b0);
        chk("unwind_pc", 32'(out_pc), 2);

        // Underflow, clear race, reset mid-operation.
        go_branch(7);
        go_ret(1'b0);
        chk("unf_pc", 32'(out_pc), 7);
        chk("unf_flag", 32'(bus.err_unf), 1);
        go_ret(1'b1);
        chk("unf_race", 32'(bus.err_unf), 1);
        go_call(20);
        go_call(33);
        idle();
        rst = 1'b1;
        tick();
        chk("rst_mid_pc", 32'(out_pc), 0);
        chk("rst_mid_unf", 32'(bus.err_unf), 0);

        // Write to the current PC address, then tri-state.
        go_branch(12);
        idle();
        bus.prog_we   = 1'b1;
        bus.prog_addr = PC_W'(12);
        bus.prog_data = IW'(10'h3FF);
        #1;
        chk("wr_old", 32'(bus.instruction), 32'(m_store[12]));
        tick();
        chk("wr_new", 32'(bus.instruction), 32'h3FF);
        idle();
        bus.export_pc = 1'b0;
        tick();
        chk("tri_z", 32'(out_pc), 32'h3F);
        idle();
        tick();
        chk("tri_on", 32'(out_pc), 12);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            idle();
            rst           = ($urandom_range(0, 49) == 0);
            bus.branch    = ($urandom_range(0, 5) == 0);
            bus.call      = ($urandom_range(0, 3) == 0);
            bus.ret       = ($urandom_range(0, 3) == 0);
            bus.done      = ($urandom_range(0, 1) == 0);
            bus.err_clr   = ($urandom_range(0, 7) == 0);
            bus.export_pc = ($urandom_range(0, 3) != 0);
            bus.target    = PC_W'($urandom);
            bus.prog_we   = ($urandom_range(0, 3) == 0);
            bus.prog_addr = PC_W'($urandom);
            bus.prog_data = IW'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
